mux_arb_nto1: RTL and testbench

Parametrised, registered N-to-1 data selector with valid/ready handshaking on every input channel and on the output.

- Successor to the fixed 8-way 4-bit multiplier selector; datapath is now sequential and generalised in width and channel count.
- Two selection modes: external select, or round-robin arbitration across channels.
- Sits between the multiplier's partial-product sources and the accumulator, and is reusable wherever several producers share one consumer.

---
 rtl/mux_arb_nto1.sv | 193 +++++++++++++++++++
 tb/tb_mux_arb_nto1.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: registered N-to-1 selector with valid/ready handshaking on
// every input channel and on the output. Channel choice is either an
// external select (Mode=0) or round-robin arbitration (Mode=1).
// Optional packet locking is compiled in with `define MUX_ARB_LOCK_EN, which
// adds InLast/OutLast and keeps a round-robin grant on one channel until the
// beat carrying InLast.
module mux_arb_nto1 #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [CHANNELS*WIDTH-1:0] InData,
  input  logic [CHANNELS-1:0]       InValid,
  output logic [CHANNELS-1:0]       InReady,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Sel,
  output logic [WIDTH-1:0]          OutData,
  output logic [SEL_W-1:0]          OutChan,
  output logic                      OutValid,
  input  logic                      OutReady
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic [CHANNELS-1:0]       InLast,
  output logic                      OutLast
`endif
);

  localparam logic [SEL_W:0]   CH_COUNT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]    ptr;
  logic                load_en;
  logic                sel_in_range;
  logic [CHANNELS-1:0] rot_valid;
  logic                rr_found;
  logic [SEL_W-1:0]    rr_offset;
  logic [SEL_W:0]      rr_sum;
  logic [SEL_W-1:0]    rr_chan;
  logic                grant_any;
  logic [SEL_W-1:0]    grant_chan;
  logic                xfer;
  logic                grant_last;
  logic [WIDTH-1:0]    grant_data;
  logic [SEL_W-1:0]    ptr_next;

`ifdef MUX_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  lock_state_t      lock_state;
  logic [SEL_W-1:0] lock_chan;
`endif

  // The output register may take a new beat when empty or being drained.
  assign load_en = !OutValid || OutReady;

  // Out-of-range selects (non power-of-two channel counts) never grant.
  assign sel_in_range = ({1'b0, Sel} < CH_COUNT);

  // Rotate the valid vector so bit 0 corresponds to the pointer position.
  assign rot_valid = CHANNELS'({InValid, InValid} >> ptr);

  // Find the nearest valid channel at or after the pointer.
  always_comb begin
    rr_found  = 1'b0;
    rr_offset = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        rr_found  = 1'b1;
        rr_offset = SEL_W'(i);
      end
    end
  end

  // Convert the rotated offset back to an absolute channel index.
  always_comb begin
    rr_sum = {1'b0, ptr} + {1'b0, rr_offset};
    if (rr_sum >= CH_COUNT) begin
      rr_chan = SEL_W'(rr_sum - CH_COUNT);
    end else begin
      rr_chan = rr_sum[SEL_W-1:0];
    end
  end

  // Pick at most one channel to grant this cycle; nothing is granted in reset.
  always_comb begin
    grant_any  = 1'b0;
    grant_chan = '0;
    if (Rst_n && load_en) begin
      if (!Mode) begin
        if (sel_in_range && InValid[Sel]) begin
          grant_any  = 1'b1;
          grant_chan = Sel;
        end
      end
`ifdef MUX_ARB_LOCK_EN
      else if (lock_state == LOCKED) begin
        grant_any  = 1'b1;
        grant_chan = lock_chan;
      end
`endif
      else if (rr_found) begin
        grant_any  = 1'b1;
        grant_chan = rr_chan;
      end
    end
  end

  // Drive ready onto the granted channel only.
  always_comb begin
    InReady = '0;
    if (grant_any) begin
      InReady[grant_chan] = 1'b1;
    end
  end

  assign xfer = grant_any && InValid[grant_chan];

`ifdef MUX_ARB_LOCK_EN
  assign grant_last = InLast[grant_chan];
`else
  assign grant_last = 1'b1;
`endif

  // Select the data word of the granted channel.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_chan == SEL_W'(k)) begin
        grant_data = InData[k*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer value just past the granted channel, wrapping to zero.
  assign ptr_next = (grant_chan == LAST_CH) ? '0 : grant_chan + 1'b1;

  // Output register: load on transfer, empty when drained with nothing new.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OutValid <= 1'b0;
      OutData  <= '0;
      OutChan  <= '0;
`ifdef MUX_ARB_LOCK_EN
      OutLast  <= 1'b0;
`endif
    end else if (xfer) begin
      OutValid <= 1'b1;
      OutData  <= grant_data;
      OutChan  <= grant_chan;
`ifdef MUX_ARB_LOCK_EN
      OutLast  <= grant_last;
`endif
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

  // Round-robin pointer moves past a channel once its packet's final beat is taken.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr <= '0;
    end else if (xfer && Mode && grant_last) begin
      ptr <= ptr_next;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // Lock FSM: hold a round-robin grant on one channel until its last beat.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lock_state <= IDLE;
      lock_chan  <= '0;
    end else begin
      case (lock_state)
        IDLE: begin
          if (xfer && Mode && !grant_last) begin
            lock_state <= LOCKED;
            lock_chan  <= grant_chan;
          end
        end
        LOCKED: begin
          if (xfer && Mode && grant_last) begin
            lock_state <= IDLE;
          end
        end
        default: lock_state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1: self-checking bench for mux_arb_nto1 (8 channels, plus a
// 6-channel instance for out-of-range selects). Handles MUX_ARB_LOCK_EN builds.
module tb_mux_arb_nto1;

`ifdef MUX_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        Clk;
  logic        Rst_n;
  logic [31:0] InData;
  logic [7:0]  InValid;
  logic [7:0]  InReady;
  logic        Mode;
  logic [2:0]  Sel;
  logic [3:0]  OutData;
  logic [2:0]  OutChan;
  logic        OutValid;
  logic        OutReady;
  logic [7:0]  InLast;
  logic        OutLast;

  logic [5:0]  InReady6;
  logic [3:0]  OutData6;
  logic [2:0]  OutChan6;
  logic        OutValid6;
  logic        OutLast6;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit       m_valid;
  bit [3:0] m_data;
  int       m_chan;
  bit       m_last;
  int       m_ptr;
  bit       m_locked;
  int       m_lchan;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] valid;
    logic       out_ready;
    logic [7:0] exp_ready;
    logic       exp_valid;
    logic [3:0] exp_data;
    logic [2:0] exp_chan;
  } vec_t;

  vec_t vecs[19];

  mux_arb_nto1 #(.WIDTH(4), .CHANNELS(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InData(InData), .InValid(InValid),
    .InReady(InReady), .Mode(Mode), .Sel(Sel), .OutData(OutData),
    .OutChan(OutChan), .OutValid(OutValid), .OutReady(OutReady)
`ifdef MUX_ARB_LOCK_EN
    , .InLast(InLast), .OutLast(OutLast)
`endif
  );

  mux_arb_nto1 #(.WIDTH(4), .CHANNELS(6)) dut6 (
    .Clk(Clk), .Rst_n(Rst_n), .InData(InData[23:0]), .InValid(InValid[5:0]),
    .InReady(InReady6), .Mode(Mode), .Sel(Sel), .OutData(OutData6),
    .OutChan(OutChan6), .OutValid(OutValid6), .OutReady(OutReady)
`ifdef MUX_ARB_LOCK_EN
    , .InLast(InLast[5:0]), .OutLast(OutLast6)
`endif
  );

`ifndef MUX_ARB_LOCK_EN
  assign OutLast  = 1'b0;
  assign OutLast6 = 1'b0;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_chan   = 0;
    m_last   = 1'b0;
    m_ptr    = 0;
    m_locked = 1'b0;
    m_lchan  = 0;
  endtask

  // Grant decision from the rules: load only when empty or draining
  task automatic modelGrant(output bit any, output int g);
    any = 1'b0;
    g   = 0;
    if (!m_valid || OutReady) begin
      if (!Mode) begin
        if (InValid[Sel]) begin
          any = 1'b1;
          g   = int'(Sel);
        end
      end else if (m_locked) begin
        any = 1'b1;
        g   = m_lchan;
      end else begin
        for (int k = 0; k < 8; k++) begin
          int c = (m_ptr + k) % 8;
          if (!any && InValid[c]) begin
            any = 1'b1;
            g   = c;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic mode, input logic [2:0] sel, input logic [7:0] valid,
                               input logic [31:0] data, input logic out_ready, input logic [7:0] last,
                               output logic [7:0] got_ready);
    bit         any;
    int         g;
    bit         xfer;
    logic [7:0] exp_ready;
    Mode     = mode;
    Sel      = sel;
    InValid  = valid;
    InData   = data;
    OutReady = out_ready;
    InLast   = last;
    #1;
    modelGrant(any, g);
    exp_ready = any ? (8'd1 << g) : 8'd0;
    got_ready = InReady;
    checkOutput("in_ready", {24'd0, InReady}, {24'd0, exp_ready});
    xfer = any && valid[g];
    @(posedge Clk);
    if (xfer) begin
      m_valid = 1'b1;
      m_data  = data[g*4 +: 4];
      m_chan  = g;
      m_last  = LOCK_EN ? last[g] : 1'b0;
      if (mode) begin
        if (!LOCK_EN || last[g]) begin
          m_ptr    = (g + 1) % 8;
          m_locked = 1'b0;
        end else if (!m_locked) begin
          m_locked = 1'b1;
          m_lchan  = g;
        end
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    checkOutput("out_valid", {31'd0, OutValid}, {31'd0, m_valid});
    checkOutput("out_data", {28'd0, OutData}, {28'd0, m_data});
    checkOutput("out_chan", {29'd0, OutChan}, m_chan);
    if (LOCK_EN) checkOutput("out_last", {31'd0, OutLast}, {31'd0, m_last});
  endtask

  initial begin
    logic [7:0] r;
    logic [31:0] tdata;
    tdata = 32'h76A43210;

    vecs[0]  = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 4'hA, 3'd5};
    vecs[1]  = '{1'b0, 3'd7, 8'hFF, 1'b1, 8'h80, 1'b1, 4'h7, 3'd7};
    vecs[2]  = '{1'b1, 3'd0, 8'h81, 1'b1, 8'h01, 1'b1, 4'h0, 3'd0};
    vecs[3]  = '{1'b1, 3'd0, 8'h81, 1'b1, 8'h80, 1'b1, 4'h7, 3'd7};
    vecs[4]  = '{1'b1, 3'd0, 8'h81, 1'b1, 8'h01, 1'b1, 4'h0, 3'd0};
    vecs[5]  = '{1'b1, 3'd0, 8'h81, 1'b1, 8'h80, 1'b1, 4'h7, 3'd7};
    vecs[6]  = '{1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 4'h7, 3'd7};
    vecs[7]  = '{1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 4'h7, 3'd7};
    vecs[8]  = '{1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 4'h7, 3'd7};
    vecs[9]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 4'h0, 3'd0};
    vecs[10] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 4'h1, 3'd1};
    vecs[11] = '{1'b0, 3'd2, 8'h04, 1'b1, 8'h04, 1'b1, 4'h2, 3'd2};
    vecs[12] = '{1'b0, 3'd4, 8'hFF, 1'b1, 8'h10, 1'b1, 4'h4, 3'd4};
    vecs[13] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h04, 1'b1, 4'h2, 3'd2};
    vecs[14] = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 4'h2, 3'd2};
    vecs[15] = '{1'b0, 3'd3, 8'hF7, 1'b1, 8'h00, 1'b0, 4'h2, 3'd2};
    vecs[16] = '{1'b1, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h2, 3'd2};
    vecs[17] = '{1'b1, 3'd0, 8'h08, 1'b0, 8'h08, 1'b1, 4'h3, 3'd3};
    vecs[18] = '{1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 4'h3, 3'd3};

    // Power-on reset with inputs active: nothing may be granted
    Rst_n    = 1'b0;
    Mode     = 1'b1;
    Sel      = 3'd0;
    InValid  = 8'hFF;
    InData   = tdata;
    OutReady = 1'b1;
    InLast   = 8'hFF;
    modelReset();
    #3;
    checkOutput("reset out_valid", {31'd0, OutValid}, 32'd0);
    checkOutput("reset out_data", {28'd0, OutData}, 32'd0);
    checkOutput("reset out_chan", {29'd0, OutChan}, 32'd0);
    checkOutput("reset in_ready", {24'd0, InReady}, 32'd0);
    repeat (2) @(posedge Clk);
    InValid = 8'h00;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].valid, tdata, vecs[i].out_ready, 8'hFF, r);
      checkOutput($sformatf("vec%0d ready", i), {24'd0, r}, {24'd0, vecs[i].exp_ready});
      checkOutput($sformatf("vec%0d valid", i), {31'd0, OutValid}, {31'd0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d data", i), {28'd0, OutData}, {28'd0, vecs[i].exp_data});
      checkOutput($sformatf("vec%0d chan", i), {29'd0, OutChan}, {29'd0, vecs[i].exp_chan});
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                    $urandom, ($urandom_range(0, 3) != 0), 8'($urandom | $urandom), r);
    end

    // Six-channel instance: valid select grants, selects 6 and 7 do not
    applyStimulus(1'b0, 3'd5, 8'hFF, tdata, 1'b1, 8'hFF, r);
    checkOutput("ch6 sel5 out_valid", {31'd0, OutValid6}, 32'd1);
    checkOutput("ch6 sel5 out_data", {28'd0, OutData6}, 32'hA);
    checkOutput("ch6 sel5 in_ready", {26'd0, InReady6}, 32'h20);
    applyStimulus(1'b0, 3'd6, 8'hFF, tdata, 1'b1, 8'hFF, r);
    checkOutput("ch6 sel6 in_ready", {26'd0, InReady6}, 32'd0);
    checkOutput("ch6 sel6 out_valid", {31'd0, OutValid6}, 32'd0);
    applyStimulus(1'b0, 3'd7, 8'hFF, tdata, 1'b1, 8'hFF, r);
    checkOutput("ch6 sel7 in_ready", {26'd0, InReady6}, 32'd0);
    checkOutput("ch6 sel7 out_valid", {31'd0, OutValid6}, 32'd0);

    // Mid-stream reset with a beat held and the pointer moved off zero
    applyStimulus(1'b1, 3'd0, 8'h20, tdata, 1'b1, 8'hFF, r);
    applyStimulus(1'b0, 3'd1, 8'hFF, tdata, 1'b1, 8'hFF, r);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", {31'd0, OutValid}, 32'd0);
    checkOutput("midreset out_data", {28'd0, OutData}, 32'd0);
    checkOutput("midreset out_chan", {29'd0, OutChan}, 32'd0);
    checkOutput("midreset in_ready", {24'd0, InReady}, 32'd0);
    InValid = 8'h00;
    modelReset();
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    applyStimulus(1'b1, 3'd0, 8'hFF, tdata, 1'b1, 8'hFF, r);
    checkOutput("ptr zero after reset ready", {24'd0, r}, 32'h01);
    checkOutput("ptr zero after reset chan", {29'd0, OutChan}, 32'd0);

`ifdef MUX_ARB_LOCK_EN
    // Packet lock: channel 3 sends three beats with a gap, channel 4 waits
    applyStimulus(1'b1, 3'd0, 8'h18, tdata, 1'b1, 8'h00, r);
    checkOutput("lock beat1 chan", {29'd0, OutChan}, 32'd3);
    applyStimulus(1'b1, 3'd0, 8'h18, tdata, 1'b1, 8'h00, r);
    checkOutput("lock beat2 chan", {29'd0, OutChan}, 32'd3);
    applyStimulus(1'b1, 3'd0, 8'h10, tdata, 1'b1, 8'h00, r);
    checkOutput("lock stall ready", {24'd0, r}, 32'h08);
    checkOutput("lock stall valid", {31'd0, OutValid}, 32'd0);
    applyStimulus(1'b1, 3'd0, 8'h18, tdata, 1'b1, 8'h18, r);
    checkOutput("lock beat3 chan", {29'd0, OutChan}, 32'd3);
    checkOutput("lock beat3 last", {31'd0, OutLast}, 32'd1);
    applyStimulus(1'b1, 3'd0, 8'h10, tdata, 1'b1, 8'h18, r);
    checkOutput("after lock chan", {29'd0, OutChan}, 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
